// File: rtl/vram_write_arbiter_if.sv
// Requester/write-port bundle between the pixel producers and the VRAM write arbiter.
// The producer side is the master; the arbiter is the slave and drives gnt and the RAM write port.
interface vram_write_arbiter_if #(
  parameter int NREQ   = 3,
  parameter int ADDR_W = 15,
  parameter int DATA_W = 12
);
  logic [NREQ-1:0]        req;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        gnt;
  logic                   wr_en;
  logic [ADDR_W-1:0]      wr_addr;
  logic [DATA_W-1:0]      wr_data;
  logic                   wr_cs_a;
  logic                   wr_cs_b;

  modport master (
    output req, req_addr, req_data,
    input  gnt, wr_en, wr_addr, wr_data, wr_cs_a, wr_cs_b
  );

  modport slave (
    input  req, req_addr, req_data,
    output gnt, wr_en, wr_addr, wr_data, wr_cs_a, wr_cs_b
  );
endinterface

// File: rtl/vram_write_arbiter.sv
// Round-robin write arbiter for the double-buffered strip VRAM, with a frame-aligned
// front/back swap sequencer that never lets a swap split an in-flight write.
module vram_write_arbiter #(
  parameter int NREQ   = 3,
  parameter int ADDR_W = 15,
  parameter int DATA_W = 12,
  parameter int DEPTH  = 20480
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 frame_tick,
  input  logic                 swap_req,
  vram_write_arbiter_if.slave  bus,
  output logic                 front_sel,
  output logic                 swap_done,
  output logic                 addr_err,
  output logic                 busy
);

  localparam int                PTR_W   = (NREQ > 2) ? 2 : 1;
  localparam logic [PTR_W:0]    NREQ_P  = (PTR_W + 1)'(NREQ);
  localparam logic [ADDR_W-1:0] DEPTH_P = ADDR_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_SWAP    = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic                carry_r, carry_s;
  logic                grant_ok_s;
  logic [PTR_W-1:0]    ptr_r;
  logic [PTR_W-1:0]    idx_s;
  logic [PTR_W-1:0]    gidx_s;
  logic                accept_s;
  logic [NREQ-1:0]     gnt_s;
  logic [ADDR_W-1:0]   addr_arr_s [NREQ];
  logic [DATA_W-1:0]   data_arr_s [NREQ];
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_data_s;
  logic                legal_s;

  logic                wr_en_r;
  logic [ADDR_W-1:0]   wr_addr_r;
  logic [DATA_W-1:0]   wr_data_r;
  logic                wr_cs_a_r;
  logic                wr_cs_b_r;
  logic                front_sel_r;
  logic                toggled_r;
  logic                swap_done_r;
  logic                addr_err_r;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input logic [PTR_W:0]   off);
    logic [PTR_W:0] sum;
    sum = {1'b0, base} + off;
    if (sum >= NREQ_P) begin
      sum = sum - NREQ_P;
    end else begin
      sum = sum;
    end
    return sum[PTR_W-1:0];
  endfunction

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_arr_s[g] = bus.req_addr[g*ADDR_W +: ADDR_W];
    assign data_arr_s[g] = bus.req_data[g*DATA_W +: DATA_W];
  end

  // Swap sequencer state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      carry_r <= 1'b0;
    end else begin
      state_r <= state_s;
      carry_r <= carry_s;
    end
  end

  // Swap next-state; grants are blocked while the write port drains and the buffers flip
  always_comb begin
    state_s    = state_r;
    carry_s    = carry_r;
    grant_ok_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        grant_ok_s = reset_n;
        if (swap_req || carry_r) begin
          carry_s = 1'b0;
          state_s = frame_tick ? ST_DRAIN : ST_PENDING;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PENDING: begin
        grant_ok_s = reset_n;
        if (frame_tick) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_PENDING;
        end
      end
      ST_DRAIN: begin
        carry_s = carry_r | swap_req;
        state_s = ST_SWAP;
      end
      ST_SWAP: begin
        carry_s = carry_r | swap_req;
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        carry_s = 1'b0;
      end
    endcase
  end

  // Scanning from the far end down lets the lowest offset from ptr win
  always_comb begin
    gnt_s    = '0;
    gidx_s   = '0;
    idx_s    = '0;
    accept_s = 1'b0;
    if (grant_ok_s) begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        idx_s    = wrap_add(ptr_r, k[PTR_W:0]);
        gidx_s   = bus.req[idx_s] ? idx_s : gidx_s;
        accept_s = accept_s | bus.req[idx_s];
      end
      gnt_s[gidx_s] = accept_s;
    end else begin
      gnt_s = '0;
    end
  end

  assign sel_addr_s = addr_arr_s[gidx_s];
  assign sel_data_s = data_arr_s[gidx_s];
  assign legal_s    = (sel_addr_s < DEPTH_P);

  // Round-robin priority pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_r <= '0;
    end else if (accept_s) begin
      ptr_r <= wrap_add(gidx_s, (PTR_W + 1)'(1'b1));
    end
  end

  // Write port register; illegal addresses are consumed but never strobed into RAM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en_r    <= 1'b0;
      wr_addr_r  <= '0;
      wr_data_r  <= '0;
      wr_cs_a_r  <= 1'b0;
      wr_cs_b_r  <= 1'b0;
      addr_err_r <= 1'b0;
    end else if (accept_s && legal_s) begin
      wr_en_r    <= 1'b1;
      wr_addr_r  <= sel_addr_s;
      wr_data_r  <= sel_data_s;
      wr_cs_a_r  <= front_sel_r;
      wr_cs_b_r  <= ~front_sel_r;
    end else begin
      wr_en_r    <= 1'b0;
      wr_cs_a_r  <= 1'b0;
      wr_cs_b_r  <= 1'b0;
      addr_err_r <= addr_err_r | accept_s;
    end
  end

  // Front buffer flips on leaving SWAP; the done pulse trails it by a cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      front_sel_r <= 1'b0;
      toggled_r   <= 1'b0;
      swap_done_r <= 1'b0;
    end else begin
      front_sel_r <= front_sel_r ^ (state_r == ST_SWAP);
      toggled_r   <= (state_r == ST_SWAP);
      swap_done_r <= toggled_r;
    end
  end

  assign bus.gnt     = gnt_s;
  assign bus.wr_en   = wr_en_r;
  assign bus.wr_addr = wr_addr_r;
  assign bus.wr_data = wr_data_r;
  assign bus.wr_cs_a = wr_cs_a_r;
  assign bus.wr_cs_b = wr_cs_b_r;
  assign front_sel   = front_sel_r;
  assign swap_done   = swap_done_r;
  assign addr_err    = addr_err_r;
  assign busy        = (state_r != ST_IDLE);

endmodule
